decode_stage_hs: RTL
====================

// Module: decode_stage_hs
// PURPOSE
//  Parametrised decode stage with a valid/ready handshake. It decodes the 5-bit opcode ISA,
//  reads a 2R1W register file with write-back bypass, and registers operands, immediate and
//  control into the D/X pipeline register. Back-pressure holds the D/X contents; flush inserts a
//  bubble. A load-use hazard inserts exactly one bubble. Sits between fetch (F/D) and execute.
// PARAMETERS
//  DATA_W      32  register, PC and immediate width (>=32); immediate sign-extended to DATA_W
//  RF_ZERO     1   1: R0 reads as 0 and writes to R0 are dropped; 0: R0 is an ordinary register
//  BYPASS_EN   1   1: a same-cycle write-back to a read address returns wb_data
//  LDUSE_EN    1   1: load-use hazard detection and bubble enabled
// PORTS
//  clock      in   1       rising-edge clock
//  aclr       in   1       asynchronous reset, active-low
//  fd_valid   in   1       F/D holds a valid instruction
//  fd_ready   out  1       stage accepts fd_insn this cycle
//  fd_insn    in   32      [31:27]op [26:22]rd [21:17]rs [16:12]rt [11:7]shamt [6:2]aluop [16:0]imm
//  fd_pc      in   DATA_W  PC+1 of fd_insn
//  fd_jtgt    in   DATA_W  jump target of fd_insn
//  flush      in   1       kill D/X contents (taken branch/jump in execute)
//  wb_we, wb_addr[4:0], wb_data[DATA_W]   in   write-back port
//  dx_valid   out  1       D/X holds a valid instruction
//  dx_ready   in   1       execute accepts D/X this cycle
//  dx_rs_val, dx_rt_val, dx_pc, dx_jtgt, dx_imm   out  DATA_W   registered operands/fields
//  dx_rd, dx_rs, dx_rt, dx_shamt, dx_aluop        out  5        registered fields
//  dx_regwr, dx_memwr, dx_m2reg, dx_alusrc, dx_bne, dx_blt, dx_j, dx_jal, dx_jr   out  1
// BEHAVIOUR
//  Opcode decode: 0 ALU(regwr); 1 j; 2 bne; 3 jal(regwr); 4 jr; 5 addi(regwr, alusrc);
//    6 blt; 7 sw(memwr, alusrc); 8 lw(regwr, m2reg, alusrc); 9-31 no control (valid nop).
//  Read port B address = rd field for opcodes 2,4,6,7, else rt field. Port A address = rs.
//  dx_rd = 0 for opcodes 1,2,4,6,7 (no destination).
//  Register file: 32 x DATA_W flops, all cleared by aclr; write on the clock edge when wb_we=1.
//  Bypass (BYPASS_EN=1): read addr == wb_addr, wb_we=1 (and addr!=0 if RF_ZERO) -> wb_data.
//  Load-use hazard: dx_valid & dx_m2reg & dx_rd!=0 & (dx_rd==rs | dx_rd==portB addr), with the
//    compared port actually used by the opcode (port A: ops 0,2,4,5,6,7,8; port B: ops 0,2,4,6,7).
//  fd_ready = (~dx_valid | dx_ready) & ~hazard & ~flush.
//  Edge update, in priority order:
//    1. flush=1 -> dx_valid=0 and all control bits/dx_rd=0. The F/D instruction is not consumed.
//    2. fd_valid & fd_ready -> load all dx_* fields from decode; dx_valid=1. Latency is 1 cycle.
//    3. (~dx_valid | dx_ready) & (hazard | ~fd_valid) -> bubble: dx_valid=0, control and dx_rd=0.
//    4. otherwise (dx_valid & ~dx_ready) -> hold all dx_* unchanged.
//  A bubble leaves data fields as don't-care, but the implementation retains them.
//  A hazard costs exactly one bubble: after the bubble, dx_m2reg=0 and the instruction issues.
//  Reset (aclr low, any time, including mid-handshake): every dx_* output is 0, dx_valid=0, and
//    the register file is 0. fd_ready is combinational, so it is 1 during reset.
//  Simultaneous wb write and read of the same register: BYPASS_EN=1 returns new data; BYPASS_EN=0 returns old data.
//  With RF_ZERO=1, a write of R0 is ignored and R0 reads 0 even when bypassing.
// TESTING
//  1. Reset, then wb R5=0x1234 and issue ALU rs=5,rt=0 -> next cycle dx_valid=1, dx_rs_val=0x1234, dx_rt_val=0.
//  2. wb R7=0xBEEF in the same cycle as decoding addi rs=7 -> dx_rs_val=0xBEEF with BYPASS_EN=1,
//     and the old value with BYPASS_EN=0.
//  3. lw rd=3 followed by ALU rs=3 -> one cycle with fd_ready=0 and dx_valid=0, then the ALU issues.
//     With lw rd=0 there is no bubble.
//  4. Hold dx_ready=0 for 3 cycles with fd_valid=1 -> fd_ready=0 and dx_* stable; the next
//     instruction loads on the cycle after dx_ready returns to 1.
//  5. flush=1 while fd_valid=1 -> dx_valid=0 and dx_regwr=0; the same fd_insn issues the next cycle.
//  6. Drop aclr mid-stream with dx_valid=1 -> all dx_*=0 and R1..R31 read 0 after release.
//     Also: imm 0x10000 sign-extends to 0xFFFF_0000.

Source files
------------

// File: rtl/decode_stage_hs.sv
// Decode stage: opcode decode, 2R1W register file with write-back bypass,
// load-use bubble and a valid/ready handshake into the D/X register.
// Ports: clock/aclr; F/D side fd_valid/fd_ready/fd_insn/fd_pc/fd_jtgt;
// flush; write-back wb_we/wb_addr/wb_data; D/X side dx_valid/dx_ready/dx_*.
module decode_stage_hs #(
  parameter int DATA_W    = 32,
  parameter int RF_ZERO   = 1,
  parameter int BYPASS_EN = 1,
  parameter int LDUSE_EN  = 1
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              fd_valid,
  output logic              fd_ready,
  input  logic [31:0]       fd_insn,
  input  logic [DATA_W-1:0] fd_pc,
  input  logic [DATA_W-1:0] fd_jtgt,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              dx_valid,
  input  logic              dx_ready,
  output logic [DATA_W-1:0] dx_rs_val,
  output logic [DATA_W-1:0] dx_rt_val,
  output logic [DATA_W-1:0] dx_pc,
  output logic [DATA_W-1:0] dx_jtgt,
  output logic [DATA_W-1:0] dx_imm,
  output logic [4:0]        dx_rd,
  output logic [4:0]        dx_rs,
  output logic [4:0]        dx_rt,
  output logic [4:0]        dx_shamt,
  output logic [4:0]        dx_aluop,
  output logic              dx_regwr,
  output logic              dx_memwr,
  output logic              dx_m2reg,
  output logic              dx_alusrc,
  output logic              dx_bne,
  output logic              dx_blt,
  output logic              dx_j,
  output logic              dx_jal,
  output logic              dx_jr
);

  typedef struct packed {
    logic regwr;
    logic memwr;
    logic m2reg;
    logic alusrc;
    logic bne;
    logic blt;
    logic j;
    logic jal;
    logic jr;
  } ctrl_t;

  localparam logic [4:0] OpAlu  = 5'd0;
  localparam logic [4:0] OpJ    = 5'd1;
  localparam logic [4:0] OpBne  = 5'd2;
  localparam logic [4:0] OpJal  = 5'd3;
  localparam logic [4:0] OpJr   = 5'd4;
  localparam logic [4:0] OpAddi = 5'd5;
  localparam logic [4:0] OpBlt  = 5'd6;
  localparam logic [4:0] OpSw   = 5'd7;
  localparam logic [4:0] OpLw   = 5'd8;

  // Instruction fields
  logic [4:0]  op;
  logic [4:0]  rdF;
  logic [4:0]  rsF;
  logic [4:0]  rtF;
  logic [4:0]  shamtF;
  logic [4:0]  aluopF;
  logic [16:0] immF;

  assign op     = fd_insn[31:27];
  assign rdF    = fd_insn[26:22];
  assign rsF    = fd_insn[21:17];
  assign rtF    = fd_insn[16:12];
  assign shamtF = fd_insn[11:7];
  assign aluopF = fd_insn[6:2];
  assign immF   = fd_insn[16:0];

  // Decode
  ctrl_t       ctrl;
  logic        useA;
  logic        useB;
  logic        bFromRd;
  logic        noDest;
  logic [4:0]  bAddr;
  logic [4:0]  rdDec;
  logic [DATA_W-1:0] immExt;

  always_comb begin
    ctrl    = '0;
    useA    = 1'b0;
    useB    = 1'b0;
    bFromRd = 1'b0;
    noDest  = 1'b0;
    unique case (op)
      OpAlu: begin
        ctrl.regwr = 1'b1;
        useA       = 1'b1;
        useB       = 1'b1;
      end
      OpJ: begin
        ctrl.j = 1'b1;
        noDest = 1'b1;
      end
      OpBne: begin
        ctrl.bne = 1'b1;
        useA     = 1'b1;
        useB     = 1'b1;
        bFromRd  = 1'b1;
        noDest   = 1'b1;
      end
      OpJal: begin
        ctrl.jal   = 1'b1;
        ctrl.regwr = 1'b1;
      end
      OpJr: begin
        ctrl.jr = 1'b1;
        useA    = 1'b1;
        useB    = 1'b1;
        bFromRd = 1'b1;
        noDest  = 1'b1;
      end
      OpAddi: begin
        ctrl.regwr  = 1'b1;
        ctrl.alusrc = 1'b1;
        useA        = 1'b1;
      end
      OpBlt: begin
        ctrl.blt = 1'b1;
        useA     = 1'b1;
        useB     = 1'b1;
        bFromRd  = 1'b1;
        noDest   = 1'b1;
      end
      OpSw: begin
        ctrl.memwr  = 1'b1;
        ctrl.alusrc = 1'b1;
        useA        = 1'b1;
        useB        = 1'b1;
        bFromRd     = 1'b1;
        noDest      = 1'b1;
      end
      OpLw: begin
        ctrl.regwr  = 1'b1;
        ctrl.m2reg  = 1'b1;
        ctrl.alusrc = 1'b1;
        useA        = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign bAddr  = bFromRd ? rdF : rtF;
  assign rdDec  = noDest ? 5'd0 : rdF;
  assign immExt = {{(DATA_W-17){immF[16]}}, immF};

  // Register file
  logic [DATA_W-1:0] rf [32];
  logic              wrEn;

  assign wrEn = wb_we & ~((RF_ZERO != 0) & (wb_addr == 5'd0));

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wrEn) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Read ports; the R0 override comes last so it also masks the bypass.
  logic [DATA_W-1:0] aVal;
  logic [DATA_W-1:0] bVal;

  always_comb begin
    aVal = rf[rsF];
    if ((BYPASS_EN != 0) && wb_we && (wb_addr == rsF)) begin
      aVal = wb_data;
    end
    if ((RF_ZERO != 0) && (rsF == 5'd0)) begin
      aVal = '0;
    end
  end

  always_comb begin
    bVal = rf[bAddr];
    if ((BYPASS_EN != 0) && wb_we && (wb_addr == bAddr)) begin
      bVal = wb_data;
    end
    if ((RF_ZERO != 0) && (bAddr == 5'd0)) begin
      bVal = '0;
    end
  end

  // Load-use hazard against the load sitting in D/X
  ctrl_t dxCtrl;
  logic  hazard;
  logic  slotFree;

  assign hazard = (LDUSE_EN != 0) & dx_valid & dxCtrl.m2reg &
                  (dx_rd != 5'd0) &
                  ((useA & (dx_rd == rsF)) |
                   (useB & (dx_rd == bAddr)));

  assign slotFree = ~dx_valid | dx_ready;
  assign fd_ready = slotFree & ~hazard & ~flush;

  // D/X register
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      dx_valid  <= 1'b0;
      dxCtrl    <= '0;
      dx_rs_val <= '0;
      dx_rt_val <= '0;
      dx_pc     <= '0;
      dx_jtgt   <= '0;
      dx_imm    <= '0;
      dx_rd     <= '0;
      dx_rs     <= '0;
      dx_rt     <= '0;
      dx_shamt  <= '0;
      dx_aluop  <= '0;
    end else if (flush) begin
      dx_valid <= 1'b0;
      dxCtrl   <= '0;
      dx_rd    <= '0;
    end else if (fd_valid && fd_ready) begin
      dx_valid  <= 1'b1;
      dxCtrl    <= ctrl;
      dx_rs_val <= aVal;
      dx_rt_val <= bVal;
      dx_pc     <= fd_pc;
      dx_jtgt   <= fd_jtgt;
      dx_imm    <= immExt;
      dx_rd     <= rdDec;
      dx_rs     <= rsF;
      dx_rt     <= rtF;
      dx_shamt  <= shamtF;
      dx_aluop  <= aluopF;
    end else if (slotFree && (hazard || !fd_valid)) begin
      // Bubble: data fields are kept, only validity and control drop.
      dx_valid <= 1'b0;
      dxCtrl   <= '0;
      dx_rd    <= '0;
    end
  end

  assign dx_regwr  = dxCtrl.regwr;
  assign dx_memwr  = dxCtrl.memwr;
  assign dx_m2reg  = dxCtrl.m2reg;
  assign dx_alusrc = dxCtrl.alusrc;
  assign dx_bne    = dxCtrl.bne;
  assign dx_blt    = dxCtrl.blt;
  assign dx_j      = dxCtrl.j;
  assign dx_jal    = dxCtrl.jal;
  assign dx_jr     = dxCtrl.jr;

endmodule
